// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-unit state encoding and datapath widths.
package cpu_pkg;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    IFETCH_IDLE = 2'd0,
    IFETCH_WAIT = 2'd1,
    IFETCH_DROP = 2'd2
  } ifetch_state_t;

endpackage

// File: rtl/ifetch_linebuf.sv
// One-word instruction line buffer: tag/data/valid, hit compare and halfword mux.
// Lookup is combinational; writes take effect on the next clock edge.
module ifetch_linebuf #(
  parameter int TAG_W   = cpu_pkg::ADDR_W - 2,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int DATA_W  = cpu_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [TAG_W-1:0]   rd_tag,
  input  logic               rd_sel,
  output logic               hit,
  output logic [INSTR_W-1:0] rd_instr
);
  import cpu_pkg::*;

  logic              buf_vld;
  logic [TAG_W-1:0]  buf_tag;
  logic [DATA_W-1:0] buf_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_data <= '0;
    end else if (wr_en) begin
      buf_vld  <= 1'b1;
      buf_tag  <= wr_tag;
      buf_data <= wr_data;
    end
  end

  assign hit      = buf_vld && (buf_tag == rd_tag);
  assign rd_instr = rd_sel ? buf_data[2*INSTR_W-1:INSTR_W] : buf_data[INSTR_W-1:0];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch responder: hits return next cycle, misses return the cycle after mem_ack.
// stall holds the pc unit while a memory read is outstanding or a miss is being launched.
module ifetch_unit #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int DATA_W  = cpu_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               fetch_req,
  input  logic               flush,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_vld,
  output logic               stall,
  output logic [ADDR_W-3:0]  mem_addr,
  output logic               mem_rd,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack
);
  import cpu_pkg::*;

  ifetch_state_t      state;
  logic               sel;
  logic               hit;
  logic               accept;
  logic               buf_wr;
  logic [INSTR_W-1:0] hit_instr;
  logic [INSTR_W-1:0] ack_instr;
  logic               unused_pc0;

  assign unused_pc0 = pc[0];
  assign accept     = fetch_req & ~flush;
  // Any ack taken outside IDLE is real code, even when flushed, so it always fills the buffer.
  assign buf_wr     = mem_ack & (state != IFETCH_IDLE);
  assign ack_instr  = sel ? mem_rdata[2*INSTR_W-1:INSTR_W] : mem_rdata[INSTR_W-1:0];
  assign stall      = (state != IFETCH_IDLE) | (accept & ~hit);

  ifetch_linebuf #(
    .TAG_W  (ADDR_W - 2),
    .INSTR_W(INSTR_W),
    .DATA_W (DATA_W)
  ) u_linebuf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (buf_wr),
    .wr_tag  (mem_addr),
    .wr_data (mem_rdata),
    .rd_tag  (pc[ADDR_W-1:2]),
    .rd_sel  (pc[1]),
    .hit     (hit),
    .rd_instr(hit_instr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IFETCH_IDLE;
      sel       <= 1'b0;
      instr     <= '0;
      instr_vld <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      instr_vld <= 1'b0;
      case (state)
        IFETCH_IDLE: begin
          if (accept) begin
            if (hit) begin
              instr     <= hit_instr;
              instr_vld <= 1'b1;
            end else begin
              mem_rd   <= 1'b1;
              mem_addr <= pc[ADDR_W-1:2];
              sel      <= pc[1];
              state    <= IFETCH_WAIT;
            end
          end
        end
        IFETCH_WAIT: begin
          if (mem_ack) begin
            mem_rd <= 1'b0;
            state  <= IFETCH_IDLE;
            if (!flush) begin
              instr     <= ack_instr;
              instr_vld <= 1'b1;
            end
          end else if (flush) begin
            // The read cannot be withdrawn; keep it open and discard its result.
            state <= IFETCH_DROP;
          end
        end
        IFETCH_DROP: begin
          if (mem_ack) begin
            mem_rd <= 1'b0;
            state  <= IFETCH_IDLE;
          end
        end
        default: begin
          mem_rd <= 1'b0;
          state  <= IFETCH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed vector table, hand-written reset sequence, randomized transactions.
module tb_ifetch_unit;

  logic        clk;
  logic        reset;
  logic [9:0]  pc;
  logic        fetch_req;
  logic        flush;
  logic [15:0] instr;
  logic        instr_vld;
  logic        stall;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int errors = 0;
  int checks = 0;
  logic stall_s;

  ifetch_unit dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .fetch_req(fetch_req),
    .flush    (flush),
    .instr    (instr),
    .instr_vld(instr_vld),
    .stall    (stall),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  pc;
    logic        fr;
    logic        fl;
    logic        ak;
    logic [31:0] rd;
    logic        e_stall;
    logic        e_rd;
    logic [7:0]  e_addr;
    logic        e_vld;
    logic [15:0] e_instr;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change just after a rising edge; stall is sampled at the falling edge,
  // registered outputs just after the following rising edge.
  task automatic step(input logic [9:0] p, input logic fr, input logic fl,
                      input logic ak, input logic [31:0] rd);
    pc        = p;
    fetch_req = fr;
    flush     = fl;
    mem_ack   = ak;
    mem_rdata = rd;
    @(negedge clk);
    stall_s = stall;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] memw [16];
  logic        mvld;
  logic [7:0]  mtag;
  logic [7:0]  widx;
  logic [9:0]  p;
  logic [31:0] word;
  logic [15:0] half;
  logic        hit_e;
  int          mode;
  int          d;

  initial begin
    vecs[0]  = '{10'h004, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'h01, 1'b0, 16'h0000};
    vecs[1]  = '{10'h006, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'h01, 1'b0, 16'h0000};
    vecs[2]  = '{10'h006, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'h01, 1'b0, 16'h0000};
    vecs[3]  = '{10'h006, 1'b0, 1'b0, 1'b1, 32'hABCD_1234, 1'b1, 1'b0, 8'h01, 1'b1, 16'h1234};
    vecs[4]  = '{10'h006, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 8'h01, 1'b1, 16'hABCD};
    vecs[5]  = '{10'h006, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 8'h01, 1'b0, 16'hABCD};
    vecs[6]  = '{10'h010, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'h04, 1'b0, 16'hABCD};
    vecs[7]  = '{10'h010, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 8'h04, 1'b0, 16'hABCD};
    vecs[8]  = '{10'h010, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 8'h04, 1'b0, 16'hABCD};
    vecs[9]  = '{10'h010, 1'b0, 1'b0, 1'b1, 32'h5555_AAAA, 1'b1, 1'b0, 8'h04, 1'b0, 16'hABCD};
    vecs[10] = '{10'h012, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 8'h04, 1'b1, 16'h5555};
    vecs[11] = '{10'h020, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'h08, 1'b0, 16'h5555};
    vecs[12] = '{10'h020, 1'b0, 1'b1, 1'b1, 32'h1357_2468, 1'b1, 1'b0, 8'h08, 1'b0, 16'h5555};
    vecs[13] = '{10'h020, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 8'h08, 1'b1, 16'h2468};
    vecs[14] = '{10'h040, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 8'h08, 1'b0, 16'h2468};
    vecs[15] = '{10'h040, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'h10, 1'b0, 16'h2468};
    vecs[16] = '{10'h040, 1'b0, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0, 8'h10, 1'b1, 16'hF00D};
    vecs[17] = '{10'h040, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h10, 1'b0, 16'hF00D};
    vecs[18] = '{10'h042, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 8'h10, 1'b1, 16'h0BAD};

    reset = 1'b1; pc = '0; fetch_req = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset instr", instr, 16'h0);
    chk("reset instr_vld", instr_vld, 1'b0);
    chk("reset mem_rd", mem_rd, 1'b0);
    chk("reset mem_addr", mem_addr, 8'h0);
    chk("reset stall", stall, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].pc, vecs[i].fr, vecs[i].fl, vecs[i].ak, vecs[i].rd);
      chk($sformatf("vec%0d stall", i), stall_s, vecs[i].e_stall);
      chk($sformatf("vec%0d mem_rd", i), mem_rd, vecs[i].e_rd);
      chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d instr_vld", i), instr_vld, vecs[i].e_vld);
      chk($sformatf("vec%0d instr", i), instr, vecs[i].e_instr);
    end

    // Asynchronous reset in the middle of a WAIT, then a stray ack.
    step(10'h080, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_wait mem_rd", mem_rd, 1'b1);
    fetch_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_async mem_rd", mem_rd, 1'b0);
    chk("rst_async instr_vld", instr_vld, 1'b0);
    chk("rst_async instr", instr, 16'h0);
    chk("rst_async stall", stall, 1'b0);
    chk("rst_async mem_addr", mem_addr, 8'h0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(10'h080, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("stray_ack stall", stall_s, 1'b0);
    chk("stray_ack instr_vld", instr_vld, 1'b0);
    chk("stray_ack mem_rd", mem_rd, 1'b0);
    step(10'h006, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("post_rst miss stall", stall_s, 1'b1);
    chk("post_rst miss mem_rd", mem_rd, 1'b1);
    chk("post_rst miss mem_addr", mem_addr, 8'h01);
    step(10'h006, 1'b0, 1'b0, 1'b1, 32'h9999_8888);
    chk("post_rst instr_vld", instr_vld, 1'b1);
    chk("post_rst instr", instr, 16'h9999);

    // Randomized transactions against a word-level model of memory and the line buffer.
    for (int i = 0; i < 16; i++) memw[i] = $urandom;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step(10'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    mvld = 1'b0;
    mtag = '0;
    for (int t = 0; t < 80; t++) begin
      widx  = 8'($urandom_range(0, 15));
      p     = {widx, 2'($urandom_range(0, 3))};
      mode  = $urandom_range(0, 3);
      word  = memw[widx];
      half  = p[1] ? word[31:16] : word[15:0];
      hit_e = mvld && (mtag == widx);
      step(p, 1'b1, mode == 1, 1'b0, 32'h0);
      chk($sformatf("rnd%0d req stall", t), stall_s, (mode != 1) && !hit_e);
      if (mode == 1) begin
        chk($sformatf("rnd%0d flushreq vld", t), instr_vld, 1'b0);
        chk($sformatf("rnd%0d flushreq mem_rd", t), mem_rd, 1'b0);
      end else if (hit_e) begin
        chk($sformatf("rnd%0d hit vld", t), instr_vld, 1'b1);
        chk($sformatf("rnd%0d hit instr", t), instr, half);
        chk($sformatf("rnd%0d hit mem_rd", t), mem_rd, 1'b0);
      end else begin
        chk($sformatf("rnd%0d miss mem_rd", t), mem_rd, 1'b1);
        chk($sformatf("rnd%0d miss mem_addr", t), mem_addr, widx);
        d = (mode == 2) ? $urandom_range(1, 3) : $urandom_range(0, 3);
        for (int k = 0; k < d; k++) begin
          step(p, 1'b0, (mode == 2) && (k == 0), 1'b0, 32'h0);
          chk($sformatf("rnd%0d wait stall", t), stall_s, 1'b1);
          chk($sformatf("rnd%0d wait mem_rd", t), mem_rd, 1'b1);
          chk($sformatf("rnd%0d wait vld", t), instr_vld, 1'b0);
        end
        step(p, 1'b0, mode == 3, 1'b1, word);
        chk($sformatf("rnd%0d ack stall", t), stall_s, 1'b1);
        chk($sformatf("rnd%0d ack mem_rd", t), mem_rd, 1'b0);
        chk($sformatf("rnd%0d ack vld", t), instr_vld, mode == 0);
        if (mode == 0) chk($sformatf("rnd%0d ack instr", t), instr, half);
        mvld = 1'b1;
        mtag = widx;
      end
      step(p, 1'b0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("rnd%0d idle vld", t), instr_vld, 1'b0);
      chk($sformatf("rnd%0d idle stall", t), stall_s, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
